// File: rtl/saturn_bus_responder_pkg.sv
// Types private to the Saturn bus responder: FSM state encoding.
// Latency: n/a (types only).
// Backpressure: n/a.
package saturn_bus_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ_PC,
    ST_READ_DP,
    ST_WRITE_PC,
    ST_WRITE_DP,
    ST_LOAD_PC,
    ST_LOAD_DP,
    ST_LOAD_CFG
  } state_t;

  // Last nibble index of a 5-nibble address load.
  localparam logic [2:0] LOAD_LAST_CNT = 3'd4;

endpackage

// File: rtl/saturn_def_buscmd.sv
// Saturn nibble bus command codes and address width, shared by controller and responders.
// Latency: n/a (constants only).
// Backpressure: n/a; the bus has no flow control, the controller owns all timing.
package saturn_def_buscmd;

  localparam int unsigned SATURN_ADDR_W = 20;

  localparam logic [3:0] CMD_NOP         = 4'h0;
  localparam logic [3:0] CMD_PC_READ     = 4'h2;
  localparam logic [3:0] CMD_DP_READ     = 4'h3;
  localparam logic [3:0] CMD_PC_WRITE    = 4'h4;
  localparam logic [3:0] CMD_DP_WRITE    = 4'h5;
  localparam logic [3:0] CMD_LOAD_PC     = 4'h6;
  localparam logic [3:0] CMD_LOAD_DP     = 4'h7;
  localparam logic [3:0] CMD_CONFIGURE   = 4'h8;
  localparam logic [3:0] CMD_UNCONFIGURE = 4'h9;
  localparam logic [3:0] CMD_BUS_RESET   = 4'hA;

endpackage

// File: rtl/saturn_nibble_ram.sv
// Nibble memory behind the responder: synchronous write, asynchronous read.
// Latency: read is combinational; write lands on the clock edge.
// Backpressure: none; a write strobe is always accepted (ignored when not writable).
// Ports: i_clk, i_we (write enable), i_addr (nibble index), i_wdata, o_rdata.
module saturn_nibble_ram #(
  parameter int unsigned ADDR_BITS = 10,
  parameter bit          WRITABLE  = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [3:0]           i_wdata,
  output logic [3:0]           o_rdata
);

  logic [3:0] mem [2**ADDR_BITS];

  // Contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (i_we && WRITABLE) begin
      mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_addr];

endmodule

// File: rtl/saturn_bus_responder.sv
// Saturn nibble bus slave: command decode, PC/DP pointers, memory window at a movable base.
// Latency: read data and o_bus_drive are registered, valid the cycle after the read strobe.
// Backpressure: none; every strobe (including back-to-back) is processed in its cycle.
// Ports: i_clk, i_reset_n (async, active low), i_bus_clk_en/i_bus_is_data/i_bus_nibble_in
//        from the controller; o_bus_nibble_out/o_bus_drive read return; o_configured, o_error.
module saturn_bus_responder
  import saturn_def_buscmd::*;
  import saturn_bus_responder_pkg::*;
#(
  parameter int unsigned             ADDR_BITS    = 10,
  parameter bit                      WRITABLE     = 1'b1,
  parameter bit                      CONFIGURABLE = 1'b1,
  parameter logic [SATURN_ADDR_W-1:0] RESET_BASE  = 20'h00000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_bus_clk_en,
  input  logic       i_bus_is_data,
  input  logic [3:0] i_bus_nibble_in,
  output logic [3:0] o_bus_nibble_out,
  output logic       o_bus_drive,
  output logic       o_configured,
  output logic       o_error
);

  localparam int unsigned AW = SATURN_ADDR_W;

  state_t         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [15:0]    shadow_q, shadow_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [AW-1:0]  dp_q, dp_d;
  logic [AW-1:0]  base_q, base_d;
  logic           configured_q, configured_d;
  logic           error_q, error_d;
  logic [3:0]     nib_out_q, nib_out_d;
  logic           drive_q, drive_d;

  logic [AW-1:0]  ptr;
  logic           ptr_is_pc;
  logic           hit;
  logic           ram_we;
  logic [3:0]     ram_rdata;
  logic [AW-1:0]  load_val;

  // The pointer in use is the one the last read/write command named.
  assign ptr_is_pc = (state_q == ST_READ_PC) || (state_q == ST_WRITE_PC);
  assign ptr       = ptr_is_pc ? pc_q : dp_q;
  assign hit       = configured_q && (ptr[AW-1:ADDR_BITS] == base_q[AW-1:ADDR_BITS]);
  assign load_val  = {i_bus_nibble_in, shadow_q};

  saturn_nibble_ram #(
    .ADDR_BITS (ADDR_BITS),
    .WRITABLE  (WRITABLE)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (ram_we),
    .i_addr  (ptr[ADDR_BITS-1:0]),
    .i_wdata (i_bus_nibble_in),
    .o_rdata (ram_rdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    pc_d         = pc_q;
    dp_d         = dp_q;
    base_d       = base_q;
    configured_d = configured_q;
    error_d      = error_q;
    nib_out_d    = nib_out_q;
    drive_d      = 1'b0;           // drive only for the cycle after a read strobe
    ram_we       = 1'b0;

    if (i_bus_clk_en) begin
      if (!i_bus_is_data) begin
        // Commands preempt everything; any partial address load is dropped.
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
        case (i_bus_nibble_in)
          CMD_NOP:         ;
          CMD_PC_READ:     state_d = ST_READ_PC;
          CMD_DP_READ:     state_d = ST_READ_DP;
          CMD_PC_WRITE:    state_d = ST_WRITE_PC;
          CMD_DP_WRITE:    state_d = ST_WRITE_DP;
          CMD_LOAD_PC:     state_d = ST_LOAD_PC;
          CMD_LOAD_DP:     state_d = ST_LOAD_DP;
          CMD_CONFIGURE:   state_d = ST_LOAD_CFG;
          CMD_UNCONFIGURE: if (CONFIGURABLE) configured_d = 1'b0;
          CMD_BUS_RESET: begin
            pc_d = '0;
            dp_d = '0;
          end
          default:         error_d = 1'b1;
        endcase
      end else begin
        case (state_q)
          ST_READ_PC, ST_READ_DP: begin
            nib_out_d = hit ? ram_rdata : 4'h0;
            drive_d   = hit;
            if (ptr_is_pc) pc_d = pc_q + 20'd1;
            else           dp_d = dp_q + 20'd1;
          end
          ST_WRITE_PC, ST_WRITE_DP: begin
            ram_we = hit;
            if (ptr_is_pc) pc_d = pc_q + 20'd1;
            else           dp_d = dp_q + 20'd1;
          end
          ST_LOAD_PC, ST_LOAD_DP, ST_LOAD_CFG: begin
            if (cnt_q == LOAD_LAST_CNT) begin
              // Fifth nibble completes the address; it never enters the shadow.
              state_d = ST_IDLE;
              cnt_d   = 3'd0;
              if (state_q == ST_LOAD_PC) begin
                pc_d = load_val;
              end else if (state_q == ST_LOAD_DP) begin
                dp_d = load_val;
              end else if (CONFIGURABLE) begin
                base_d       = load_val;
                configured_d = 1'b1;
              end
            end else begin
              shadow_d[{cnt_q[1:0], 2'b00} +: 4] = i_bus_nibble_in;
              cnt_d = cnt_q + 3'd1;
            end
          end
          default: ;                // data in IDLE is ignored
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      shadow_q     <= 16'h0000;
      pc_q         <= '0;
      dp_q         <= '0;
      base_q       <= RESET_BASE;
      configured_q <= !CONFIGURABLE;
      error_q      <= 1'b0;
      nib_out_q    <= 4'h0;
      drive_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      pc_q         <= pc_d;
      dp_q         <= dp_d;
      base_q       <= base_d;
      configured_q <= configured_d;
      error_q      <= error_d;
      nib_out_q    <= nib_out_d;
      drive_q      <= drive_d;
    end
  end

  assign o_bus_nibble_out = nib_out_q;
  assign o_bus_drive      = drive_q;
  assign o_configured     = configured_q;
  assign o_error          = error_q;

endmodule

// File: tb/tb_saturn_bus_responder.sv
// Directed bench for saturn_bus_responder: a writable/configurable instance and a ROM instance.
// Latency: checks sample on the falling edge after each strobe's rising edge.
// Backpressure: n/a; the bench is the bus controller.
module tb_saturn_bus_responder;
  import saturn_bus_responder_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en, en_r, is_data;
  logic [3:0] nib;

  logic [3:0] m_nib, r_nib;
  logic       m_drv, r_drv, m_cfg, r_cfg, m_err, r_err;

  int checks   = 0;
  int failures = 0;

  saturn_bus_responder dut (
    .i_clk            (clk),
    .i_reset_n        (rst_n),
    .i_bus_clk_en     (en),
    .i_bus_is_data    (is_data),
    .i_bus_nibble_in  (nib),
    .o_bus_nibble_out (m_nib),
    .o_bus_drive      (m_drv),
    .o_configured     (m_cfg),
    .o_error          (m_err)
  );

  saturn_bus_responder #(
    .ADDR_BITS    (10),
    .WRITABLE     (1'b0),
    .CONFIGURABLE (1'b0),
    .RESET_BASE   (20'h00000)
  ) rom (
    .i_clk            (clk),
    .i_reset_n        (rst_n),
    .i_bus_clk_en     (en_r),
    .i_bus_is_data    (is_data),
    .i_bus_nibble_in  (nib),
    .o_bus_nibble_out (r_nib),
    .o_bus_drive      (r_drv),
    .o_configured     (r_cfg),
    .o_error          (r_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_data;
    logic [3:0] nib;
    logic       chk;
    logic       exp_drv;
    logic [3:0] exp_nib;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One strobe; returns on the next falling edge with the strobe still asserted.
  task automatic apply(input bit to_rom, input logic d, input logic [3:0] n);
    en      = !to_rom;
    en_r    = to_rom;
    is_data = d;
    nib     = n;
    @(negedge clk);
  endtask

  task automatic idle();
    en   = 1'b0;
    en_r = 1'b0;
    @(negedge clk);
  endtask

  task automatic load(input bit to_rom, input logic [3:0] cmd, input logic [19:0] v);
    apply(to_rom, 1'b0, cmd);
    for (int k = 0; k < 5; k++) apply(to_rom, 1'b1, v[4*k +: 4]);
  endtask

  task automatic rd(input string name, input logic exp_drv, input logic [3:0] exp_nib);
    apply(1'b0, 1'b1, 4'h0);
    check({name, "_drv"}, 20'(m_drv), 20'(exp_drv));
    check({name, "_nib"}, 20'(m_nib), 20'(exp_nib));
  endtask

  task automatic add(input logic d, input logic [3:0] n, input logic c,
                     input logic ed, input logic [3:0] en_exp);
    vec_t v;
    v.is_data = d; v.nib = n; v.chk = c; v.exp_drv = ed; v.exp_nib = en_exp;
    tbl.push_back(v);
  endtask

  logic [3:0] r0, r1;

  initial begin
    en = 0; en_r = 0; is_data = 0; nib = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #12;
    check("rst_nib", 20'(m_nib), 20'h0);
    check("rst_drv", 20'(m_drv), 20'h0);
    check("rst_cfg", 20'(m_cfg), 20'h0);
    check("rst_err", 20'(m_err), 20'h0);
    check("rst_rom_cfg", 20'(r_cfg), 20'h1);
    check("rst_pc", dut.pc_q, 20'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unconfigured read: no drive, zero data, PC still advances.
    apply(1'b0, 1'b0, 4'h2);
    rd("uncfg_rd0", 1'b0, 4'h0);
    rd("uncfg_rd1", 1'b0, 4'h0);
    idle();
    check("uncfg_pc", dut.pc_q, 20'h00002);

    // Configure, write A,B at 00405, read them back-to-back.
    add(0, 4'h8, 0, 0, 0);
    add(1, 4'h0, 0, 0, 0); add(1, 4'h0, 0, 0, 0); add(1, 4'h4, 0, 0, 0);
    add(1, 4'h0, 0, 0, 0); add(1, 4'h0, 0, 0, 0);
    add(0, 4'h6, 0, 0, 0);
    add(1, 4'h5, 0, 0, 0); add(1, 4'h0, 0, 0, 0); add(1, 4'h4, 0, 0, 0);
    add(1, 4'h0, 0, 0, 0); add(1, 4'h0, 0, 0, 0);
    add(0, 4'h4, 0, 0, 0);
    add(1, 4'hA, 0, 0, 0); add(1, 4'hB, 0, 0, 0);
    add(0, 4'h6, 0, 0, 0);
    add(1, 4'h5, 0, 0, 0); add(1, 4'h0, 0, 0, 0); add(1, 4'h4, 0, 0, 0);
    add(1, 4'h0, 0, 0, 0); add(1, 4'h0, 0, 0, 0);
    add(0, 4'h2, 0, 0, 0);
    add(1, 4'h0, 1, 1, 4'hA);
    add(1, 4'h0, 1, 1, 4'hB);
    add(0, 4'h0, 1, 0, 4'hB);
    for (int i = 0; i < tbl.size(); i++) begin
      apply(1'b0, tbl[i].is_data, tbl[i].nib);
      if (tbl[i].chk) begin
        check($sformatf("tbl%0d_drv", i), 20'(m_drv), 20'(tbl[i].exp_drv));
        check($sformatf("tbl%0d_nib", i), 20'(m_nib), 20'(tbl[i].exp_nib));
      end
    end
    idle();
    check("cfg_flag", 20'(m_cfg), 20'h1);
    check("cfg_base", dut.base_q, 20'h00400);
    check("tbl_pc", dut.pc_q, 20'h00407);
    check("idle_drv", 20'(m_drv), 20'h0);

    // BUS_RESET then a read at PC=0 outside the 00400 window.
    apply(1'b0, 1'b0, 4'hA);
    apply(1'b0, 1'b0, 4'h2);
    rd("miss_rd", 1'b0, 4'h0);
    idle();
    check("miss_pc", dut.pc_q, 20'h00001);
    check("miss_dp", dut.dp_q, 20'h00000);

    // Partial PC load abandoned by DP_READ.
    load(1'b0, 4'h7, 20'h00405);
    apply(1'b0, 1'b0, 4'h6);
    apply(1'b0, 1'b1, 4'h1);
    apply(1'b0, 1'b1, 4'h2);
    apply(1'b0, 1'b0, 4'h3);
    idle();
    check("part_pc", dut.pc_q, 20'h00001);
    check("part_state", 20'(dut.state_q), 20'(ST_READ_DP));
    rd("part_rd", 1'b1, 4'hA);
    idle();
    check("part_dp", dut.dp_q, 20'h00406);
    check("part_pc2", dut.pc_q, 20'h00001);

    // Pointer wrap at FFFFF with base FFC00.
    load(1'b0, 4'h8, 20'hFFC00);
    idle();
    check("wrap_base", dut.base_q, 20'hFFC00);
    load(1'b0, 4'h6, 20'hFFFFF);
    apply(1'b0, 1'b0, 4'h4);
    apply(1'b0, 1'b1, 4'h7);
    apply(1'b0, 1'b1, 4'h9);
    idle();
    check("wrap_wpc", dut.pc_q, 20'h00001);
    load(1'b0, 4'h6, 20'hFFFFF);
    apply(1'b0, 1'b0, 4'h2);
    rd("wrap_rd0", 1'b1, 4'h7);
    rd("wrap_rd1", 1'b0, 4'h0);
    idle();
    check("wrap_rpc", dut.pc_q, 20'h00001);

    // Unknown command: sticky error, back to IDLE.
    apply(1'b0, 1'b0, 4'hF);
    idle();
    check("err_set", 20'(m_err), 20'h1);
    check("err_state", 20'(dut.state_q), 20'(ST_IDLE));
    apply(1'b0, 1'b0, 4'h1);
    apply(1'b0, 1'b0, 4'h0);
    idle();
    check("err_sticky", 20'(m_err), 20'h1);

    // ROM: CONFIGURE/UNCONFIGURE ignored, writes leave memory unchanged.
    load(1'b1, 4'h8, 20'h00400);
    apply(1'b1, 1'b0, 4'h9);
    idle();
    check("rom_base", rom.base_q, 20'h00000);
    check("rom_cfg", 20'(r_cfg), 20'h1);
    load(1'b1, 4'h7, 20'h00010);
    apply(1'b1, 1'b0, 4'h3);
    apply(1'b1, 1'b1, 4'h0);
    r0 = r_nib;
    apply(1'b1, 1'b1, 4'h0);
    r1 = r_nib;
    load(1'b1, 4'h7, 20'h00010);
    apply(1'b1, 1'b0, 4'h5);
    apply(1'b1, 1'b1, ~r0);
    apply(1'b1, 1'b1, ~r1);
    load(1'b1, 4'h7, 20'h00010);
    apply(1'b1, 1'b0, 4'h3);
    apply(1'b1, 1'b1, 4'h0);
    check("rom_drv0", 20'(r_drv), 20'h1);
    check("rom_rd0", 20'(r_nib), 20'(r0));
    apply(1'b1, 1'b1, 4'h0);
    check("rom_rd1", 20'(r_nib), 20'(r1));
    idle();
    check("rom_dp", rom.dp_q, 20'h00012);

    // Asynchronous reset in the middle of a DP load.
    load(1'b0, 4'h6, 20'hFFFFF);
    apply(1'b0, 1'b0, 4'h2);
    rd("pre_rst_rd", 1'b1, 4'h7);
    apply(1'b0, 1'b0, 4'h7);
    apply(1'b0, 1'b1, 4'h1);
    apply(1'b0, 1'b1, 4'h2);
    apply(1'b0, 1'b1, 4'h3);
    en = 1'b0;
    check("pre_rst_nib", 20'(m_nib), 20'h7);
    #2 rst_n = 1'b0;
    #1;
    check("arst_nib", 20'(m_nib), 20'h0);
    check("arst_drv", 20'(m_drv), 20'h0);
    check("arst_cfg", 20'(m_cfg), 20'h0);
    check("arst_err", 20'(m_err), 20'h0);
    check("arst_state", 20'(dut.state_q), 20'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, 1'b1, 4'h4);
    idle();
    check("post_state", 20'(dut.state_q), 20'(ST_IDLE));
    check("post_dp", dut.dp_q, 20'h00000);
    check("post_pc", dut.pc_q, 20'h00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/saturn_bus_responder.md
Name: saturn_bus_responder

Overview:
- Slave end of the Saturn nibble bus. The bus controller is the initiator: it strobes command and data nibbles, and it strobes read cycles.
- This block decodes command nibbles and tracks its own PC and DP nibble pointers.
- It serves reads from, and accepts writes into, a nibble memory mapped at a configurable base address.
- It is a drop-in model for ROM/RAM modules on the bench, and the template for real peripherals.

Parameters:
- ADDR_BITS, 10: log2 of memory size in nibbles; the window is 2^ADDR_BITS nibbles.
- WRITABLE, 1: 0 makes the block a ROM; write strobes are ignored.
- CONFIGURABLE, 1: 0 means the block is permanently configured at RESET_BASE and the CONFIGURE command is ignored.
- RESET_BASE, 20'h00000: base address after reset; must be aligned to 2^ADDR_BITS.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_bus_clk_en  in  1  bus strobe from the controller; one nibble transfer per high cycle
- i_bus_is_data  in  1  1 = data or read strobe, 0 = command nibble
- i_bus_nibble_in  in  4  nibble driven by the controller
- o_bus_nibble_out  out  4  read data returned to the controller
- o_bus_drive  out  1  1 = o_bus_nibble_out is valid read data from this block
- o_configured  out  1  base address is valid
- o_error  out  1  sticky; set on an unknown command code

Behaviour:
- Reset: one clock with asynchronous, active-low reset (i_reset_n).
  - Reset values: o_bus_nibble_out=0, o_bus_drive=0, o_error=0, PC=0, DP=0, state=IDLE, base=RESET_BASE.
  - o_configured resets to !CONFIGURABLE.
  - Reset asserted mid-operation aborts everything; memory contents are not cleared.
- Only cycles with i_bus_clk_en=1 are acted on. All other cycles hold state, and o_bus_drive drops to 0 on the cycle after the strobe.
- Command strobe (is_data=0): always preempts the current state; a partial address shift is discarded. Codes:
  - 0 NOP: go to IDLE.
  - 2 PC_READ: state READ_PC.
  - 3 DP_READ: state READ_DP.
  - 4 PC_WRITE: state WRITE_PC.
  - 5 DP_WRITE: state WRITE_DP.
  - 6 LOAD_PC: state LOAD_PC, cnt=0.
  - 7 LOAD_DP: state LOAD_DP, cnt=0.
  - 8 CONFIGURE: state LOAD_CFG, cnt=0.
  - 9 UNCONFIGURE: o_configured=0 if CONFIGURABLE; go to IDLE.
  - A BUS_RESET: PC=DP=0; go to IDLE.
  - Any other code: o_error<=1; go to IDLE.
- LOAD_PC / LOAD_DP / LOAD_CFG, on each data strobe:
  - The nibble goes into shadow[4*cnt +: 4], least significant nibble first; cnt increments.
  - On the 5th nibble (cnt==4), the target register takes {nibble, shadow[15:0]} and the state goes to IDLE.
  - Targets: PC, DP, or base+configured. LOAD_CFG with CONFIGURABLE=0 discards the value.
- READ_PC / READ_DP, on each data strobe:
  - hit = o_configured && ptr[19:ADDR_BITS]==base[19:ADDR_BITS].
  - Registered on that edge: o_bus_nibble_out = hit ? mem[ptr[ADDR_BITS-1:0]] : 0, and o_bus_drive = hit.
  - Data is therefore valid the cycle after the strobe (latency 1).
  - ptr <= ptr+1, modulo 2^20 (FFFFF wraps to 00000). The pointer increments on a miss too.
- WRITE_PC / WRITE_DP, on each data strobe: if hit && WRITABLE, mem[ptr] <= nibble. ptr always increments.
- Data strobe in IDLE: ignored. No pointer change, no error.
- The read pointer is the one named by the command. The other pointer is untouched.
- No back-to-back restriction: strobes on consecutive cycles are each processed.

Decomposition:
- Shared include, saturn_def_buscmd: the command code constants (NOP through BUS_RESET) and the 20-bit address width constant. The bus controller uses the same include.
- Sub-module saturn_nibble_ram: 2^ADDR_BITS x 4 array, synchronous write, asynchronous read, write enable gated by WRITABLE.
- The FSM, pointers and address shift register stay in saturn_bus_responder.

Test Plan:
- Reset, then CMD 8, then data nibbles 0,0,4,0,0. Required: base=00400, o_configured=1.
  - Then CMD 6 with nibbles 5,0,4,0,0, then CMD 4, then data nibbles A,B.
  - Then CMD 6 with 5,0,4,0,0 again, then CMD 2, then two read strobes.
  - Required: reads return A then B, o_bus_drive=1 on the cycle after each strobe, PC ends at 00407.
- Read while unconfigured, and read at PC=00000 with base=00400. Required: o_bus_drive=0, nibble=0, PC increments by 1 per strobe.
- Run CMD 6 with data 1,2 only, then CMD 3. Required: PC unchanged (still its prior value), state READ_DP, next read comes from DP.
- Load PC=FFFFF, then CMD 2, then 2 strobes. Required: PC ends at 00001. With base=FFC00 the first read hits and the second misses.
- WRITABLE=0, then CMD 5 and writes. Required: memory unchanged on readback. Separately, CMD F: o_error=1 and stays 1 until i_reset_n goes low.
- Assert i_reset_n low mid LOAD_DP (after nibble 3). Required: all outputs at reset values immediately, asynchronously. After release, a data strobe does nothing.
